max_pool_2x2: RTL and testbench
===============================

# max_pool_2x2

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of the ReLU stage in the NPU datapath. It consumes one 16-bit activation per enabled cycle in row-major raster order over an IMG_W x IMG_H feature map. It emits one pooled value per 2x2 window, using a half-width line buffer to hold the horizontal maxima of the even rows. A BYPASS mode passes activations through unchanged, so the same datapath serves layers without pooling.

## Interface
Parameters:
- IMG_W, 8: feature-map width in pixels; even, >= 2.
- IMG_H, 8: feature-map height in pixels; even, >= 2.

Ports:
- CLKEXT  in  1  single system clock, rising edge.
- RST_GLO_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous frame restart: clears counters, pair register and BYPASS latch; line-buffer contents are don't-care.
- Data_IN  in  16  signed two's-complement activation (the ReLU output).
- EN_POOL  in  1  input valid; one pixel is consumed per cycle while high.
- BYPASS  in  1  pooling bypass request; sampled at the first pixel of each frame.
- POOL_OUT  out  16  pooled (or bypassed) value, registered.
- POOL_VALID  out  1  POOL_OUT is valid this cycle (single-cycle pulse per result).
- FRAME_DONE  out  1  pulses together with the last result of a frame.

## Operation
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1). Both advance only on cycles with EN_POOL=1. col wraps to 0 and increments row; row wraps to 0 after the last pixel, so the next frame starts immediately.
- Frame BYPASS latch: loaded from BYPASS when EN_POOL=1 at row=0, col=0. It is held for the whole frame. BYPASS changes mid-frame are ignored.
- Pooling mode, per accepted pixel:
  - Even col: pair_reg <= Data_IN.
  - Even row, odd col: linebuf[col>>1] <= max(pair_reg, Data_IN). No output.
  - Odd row, odd col: POOL_OUT <= max(pair_reg, Data_IN, linebuf[col>>1]) and POOL_VALID=1.
- Line buffer: IMG_W/2 entries x 16 bits. One write port and one read port, both addressed by col>>1. The read is combinational or prefetched so that the result still has 1-cycle latency.
- Compare rule: signed 16-bit compare, because BYPASSed ReLU data may be negative. On ties either operand may be chosen (the values are equal). No width growth.
- Bypass mode: every accepted pixel produces POOL_OUT <= Data_IN and POOL_VALID=1. Counters still run so frame tracking is kept. The line buffer is not written.
- FRAME_DONE=1 with the result of pixel (IMG_H-1, IMG_W-1), in both modes.
- Output count per frame: (IMG_W/2)*(IMG_H/2) in pooling mode, IMG_W*IMG_H in bypass mode.

## Timing
- Reset (RST_GLO_N=0, asynchronous): POOL_OUT=0, POOL_VALID=0, FRAME_DONE=0, col=0, row=0, pair_reg=0, BYPASS latch=0. Line-buffer contents are don't-care. Any frame in progress is abandoned; the first pixel after release is treated as (0,0).
- Latency: an accepted pixel at cycle t produces its result at cycle t+1 (POOL_VALID high in t+1 only).
- EN_POOL gaps: state is frozen, POOL_VALID=0 and POOL_OUT holds its last value. Gaps of any length, anywhere (including between the two pixels of a pair), must not change results.
- CLR and EN_POOL high in the same cycle: CLR wins. The pixel is discarded, no output is produced, and the next accepted pixel is (0,0).
- Back-to-back frames with no idle cycle are supported. The last-pixel result and the next frame's first pixel may overlap without interference.
- No backpressure: the downstream stage must accept every POOL_VALID pulse.

## Test plan
- 4x4 pooling, continuous EN_POOL, rows [1 5 2 0],[3 4 7 6],[-2 -8 9 9],[-3 -1 0 10] -> POOL_VALID one cycle after input indices 5, 7, 13 and 15, with POOL_OUT = 5, 7, -1, 10. FRAME_DONE is high with 10.
- Same frame with EN_POOL toggled randomly (gaps of 0-5 cycles) -> identical output sequence, and POOL_VALID never asserts during gaps.
- BYPASS=1 at the first pixel, 4x4 ramp 0..15 -> 16 outputs equal to the inputs, each 1 cycle later. FRAME_DONE is high with 15. BYPASS dropped mid-frame has no effect.
- Two back-to-back frames (pool, then bypass) with no idle cycle -> 4 pooled results, then 16 passthrough results, with FRAME_DONE pulsing twice.
- RST_GLO_N pulsed low after input index 6 -> all outputs are 0 immediately. Resending the full 4x4 frame -> the correct 5, 7, -1, 10 sequence.
- CLR asserted with EN_POOL at index 9 -> that pixel is dropped and the next pixel is treated as (0,0). No spurious POOL_VALID occurs.

Source files
------------

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-order feature map,
// with a per-frame bypass that forwards every activation unchanged.
module max_pool_2x2 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        CLKEXT,
  input  logic        RST_GLO_N,
  input  logic        CLR,
  input  logic [15:0] Data_IN,
  input  logic        EN_POOL,
  input  logic        BYPASS,
  output logic [15:0] POOL_OUT,
  output logic        POOL_VALID,
  output logic        FRAME_DONE
);

  localparam int CW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LBD = IMG_W / 2;
  localparam int AW  = (LBD > 1) ? $clog2(LBD) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  function automatic logic [15:0] f_smax(input logic [15:0] a, input logic [15:0] b);
    if ($signed(a) >= $signed(b)) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [15:0]   r_pair;
  logic          r_byp;
  logic [15:0]   r_out;
  logic          r_valid;
  logic          r_done;
  logic [15:0]   r_lb [LBD];

  logic          w_first;
  logic          w_byp;
  logic          w_last_col;
  logic          w_last_row;
  logic [AW-1:0] w_lb_addr;
  logic [15:0]   w_hmax;
  logic [15:0]   w_vmax;
  logic          w_lb_we;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic          w_res_valid;
  logic [15:0]   w_res_data;

  // The first pixel of a frame sees BYPASS directly; later pixels use the latch.
  assign w_first    = (r_col == {CW{1'b0}}) && (r_row == {RW{1'b0}});
  assign w_byp      = w_first ? BYPASS : r_byp;
  assign w_last_col = (r_col == COL_LAST);
  assign w_last_row = (r_row == ROW_LAST);
  assign w_lb_addr  = AW'(r_col >> 1);
  assign w_hmax     = f_smax(r_pair, Data_IN);
  assign w_vmax     = f_smax(w_hmax, r_lb[w_lb_addr]);
  assign w_lb_we    = EN_POOL & ~CLR & ~w_byp & ~r_row[0] & r_col[0];

  // Raster counter advance and result selection for the pixel on Data_IN.
  always_comb begin
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_res_valid = w_byp | (r_row[0] & r_col[0]);
    w_res_data  = w_vmax;
    if (w_last_col) begin
      w_col_nxt = {CW{1'b0}};
      if (w_last_row) begin
        w_row_nxt = {RW{1'b0}};
      end else begin
        w_row_nxt = r_row + RW'(1);
      end
    end else begin
      w_col_nxt = r_col + CW'(1);
    end
    if (w_byp) begin
      w_res_data = Data_IN;
    end else begin
      w_res_data = w_vmax;
    end
  end

  // Frame state and registered outputs; POOL_OUT holds between results.
  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      r_col   <= {CW{1'b0}};
      r_row   <= {RW{1'b0}};
      r_pair  <= 16'h0000;
      r_byp   <= 1'b0;
      r_out   <= 16'h0000;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (CLR) begin
      r_col   <= {CW{1'b0}};
      r_row   <= {RW{1'b0}};
      r_pair  <= 16'h0000;
      r_byp   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (EN_POOL) begin
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_byp   <= w_byp;
      r_valid <= w_res_valid;
      r_done  <= w_last_col & w_last_row;
      if (!r_col[0]) begin
        r_pair <= Data_IN;
      end
      if (w_res_valid) begin
        r_out <= w_res_data;
      end
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end
  end

  // Horizontal maxima of even rows; contents need no reset.
  always_ff @(posedge CLKEXT) begin
    if (w_lb_we) begin
      r_lb[w_lb_addr] <= w_hmax;
    end
  end

  assign POOL_OUT   = r_out;
  assign POOL_VALID = r_valid;
  assign FRAME_DONE = r_done;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2 on a 4x4 map: vector table, directed
// corner sequences and random frames against a window-max reference model.
module tb_max_pool_2x2;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        CLKEXT;
  logic        RST_GLO_N;
  logic        CLR;
  logic [15:0] Data_IN;
  logic        EN_POOL;
  logic        BYPASS;
  logic [15:0] POOL_OUT;
  logic        POOL_VALID;
  logic        FRAME_DONE;

  max_pool_2x2 #(.IMG_W(W), .IMG_H(H)) dut (
    .CLKEXT(CLKEXT), .RST_GLO_N(RST_GLO_N), .CLR(CLR), .Data_IN(Data_IN),
    .EN_POOL(EN_POOL), .BYPASS(BYPASS), .POOL_OUT(POOL_OUT),
    .POOL_VALID(POOL_VALID), .FRAME_DONE(FRAME_DONE)
  );

  initial CLKEXT = 1'b0;
  always #5 CLKEXT = ~CLKEXT;

  typedef struct {
    logic [15:0] d;
    logic        v;
    logic [15:0] o;
  } vec_t;

  vec_t        tbl [N];
  logic [15:0] cur_px [N];
  logic [15:0] m_last;
  bit          m_known;
  int          n_chk;
  int          n_pass;
  int          n_done;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One clock: drive inputs, let the edge pass, check outputs on the falling edge.
  task automatic cycle(input logic en, input logic [15:0] d, input logic byp,
                       input logic clr, input logic ev, input logic [15:0] eo,
                       input logic ed, input string nm);
    EN_POOL = en; Data_IN = d; BYPASS = byp; CLR = clr;
    @(posedge CLKEXT);
    @(negedge CLKEXT);
    check({nm, " valid"}, 16'(POOL_VALID), 16'(ev));
    check({nm, " done"}, 16'(FRAME_DONE), 16'(ed));
    if (FRAME_DONE) n_done++;
    if (ev) begin
      check({nm, " out"}, POOL_OUT, eo);
      m_last = eo;
      m_known = 1'b1;
    end else if (m_known && !clr) begin
      check({nm, " hold"}, POOL_OUT, m_last);
    end
    EN_POOL = 1'b0; CLR = 1'b0;
  endtask

  // Reference: result of raster pixel k given the whole frame.
  task automatic model(input int k, input bit byp, output logic ev,
                       output logic [15:0] eo, output logic ed);
    int r, c, m, v;
    r = k / W; c = k % W;
    ed = (k == N - 1);
    ev = 1'b0; eo = 16'h0000;
    if (byp) begin
      ev = 1'b1; eo = cur_px[k];
    end else if ((r % 2 == 1) && (c % 2 == 1)) begin
      m = -100000;
      for (int dr = -1; dr <= 0; dr++)
        for (int dc = -1; dc <= 0; dc++) begin
          v = int'($signed(cur_px[(r + dr) * W + c + dc]));
          if (v > m) m = v;
        end
      ev = 1'b1; eo = 16'(m);
    end
  endtask

  task automatic run_frame(input bit byp, input int gapmax);
    logic ev, ed;
    logic [15:0] eo;
    for (int k = 0; k < N; k++) begin
      int gaps;
      gaps = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      for (int g = 0; g < gaps; g++)
        cycle(1'b0, 16'($urandom), 1'($urandom), 1'b0, 1'b0, 16'h0000, 1'b0, "gap");
      model(k, byp, ev, eo, ed);
      cycle(1'b1, cur_px[k], (k == 0) ? 1'(byp) : ~1'(byp), 1'b0, ev, eo, ed, "pix");
    end
  endtask

  task automatic apply_table(input int first, input int last);
    for (int k = first; k <= last; k++)
      cycle(1'b1, tbl[k].d, 1'b0, 1'b0, tbl[k].v, tbl[k].o, 1'(k == N - 1), "tbl");
  endtask

  task automatic load_example();
    for (int k = 0; k < N; k++) cur_px[k] = tbl[k].d;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < N; k++) cur_px[k] = 16'(k);
  endtask

  initial begin
    logic [15:0] px [N];
    px = '{16'd1, 16'd5, 16'd2, 16'd0, 16'd3, 16'd4, 16'd7, 16'd6,
           -16'sd2, -16'sd8, 16'd9, 16'd9, -16'sd3, -16'sd1, 16'd0, 16'd10};
    for (int k = 0; k < N; k++) begin
      tbl[k].d = px[k]; tbl[k].v = 1'b0; tbl[k].o = 16'h0000;
    end
    tbl[5].v = 1'b1;  tbl[5].o = 16'd5;
    tbl[7].v = 1'b1;  tbl[7].o = 16'd7;
    tbl[13].v = 1'b1; tbl[13].o = 16'hFFFF;
    tbl[15].v = 1'b1; tbl[15].o = 16'd10;

    n_chk = 0; n_pass = 0; n_done = 0;
    RST_GLO_N = 1'b0; CLR = 1'b0; EN_POOL = 1'b0; BYPASS = 1'b0; Data_IN = 16'h0000;
    repeat (2) @(negedge CLKEXT);
    check("reset out", POOL_OUT, 16'h0000);
    check("reset valid", 16'(POOL_VALID), 16'h0000);
    check("reset done", 16'(FRAME_DONE), 16'h0000);
    RST_GLO_N = 1'b1;
    m_last = 16'h0000; m_known = 1'b1;

    apply_table(0, N - 1);

    load_example();
    run_frame(1'b0, 5);
    run_frame(1'b0, 5);

    load_ramp();
    run_frame(1'b1, 0);

    n_done = 0;
    load_example();
    run_frame(1'b0, 0);
    load_ramp();
    run_frame(1'b1, 0);
    check("b2b done count", 16'(n_done), 16'd2);

    // Asynchronous reset in the middle of a frame, then a full resend.
    apply_table(0, 6);
    RST_GLO_N = 1'b0;
    #1;
    check("async rst out", POOL_OUT, 16'h0000);
    check("async rst valid", 16'(POOL_VALID), 16'h0000);
    check("async rst done", 16'(FRAME_DONE), 16'h0000);
    @(negedge CLKEXT);
    RST_GLO_N = 1'b1;
    m_last = 16'h0000; m_known = 1'b1;
    apply_table(0, N - 1);

    // CLR together with a pixel drops it and restarts the frame.
    apply_table(0, 8);
    cycle(1'b1, tbl[9].d, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, "clr");
    apply_table(0, N - 1);

    // CLR in a bypass frame must also clear the latched bypass.
    load_ramp();
    cycle(1'b1, 16'd0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, "byp0");
    cycle(1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, "clr byp");
    apply_table(0, N - 1);

    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) cur_px[k] = 16'($urandom);
      run_frame(1'($urandom), 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
